// File: rtl/mul_seq_ctrl.sv
// Controller for the accumulate datapath: computes n * m by clearing the sum and
// adding n for m cycles, then captures the datapath bus and hands it out over valid/ready.
module mul_seq_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter logic [2:0]  OP_ADD = 3'b000,
    parameter logic [2:0]  OP_AND = 3'b010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] m_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] n_out,
    output logic             sel_out,
    output logic [2:0]       op_out,
    output logic             eo_out,
    input  logic [WIDTH-1:0] bus_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_READ,
        S_HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath control is decoded purely from state, so reset forces it asynchronously.
    always_comb begin
        state_nxt = state;
        sel_out   = 1'b0;
        op_out    = OP_ADD;
        eo_out    = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                op_out = OP_AND;
                if (count == '0) begin
                    state_nxt = S_READ;
                end else begin
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                sel_out = 1'b1;
                if (count == WIDTH'(1)) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                eo_out    = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (out_valid && out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // bus_in is only looked at in READ; it may float or be X everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            n_out     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_out <= n_in;
                        count <= m_in;
                    end
                end
                S_ACCUM: begin
                    count <= count - WIDTH'(1);
                end
                S_READ: begin
                    product   <= bus_in;
                    out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
